// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main controller sequencing fetch/decode/execute/memory/write-back
// with memory-ready stalls, access timeout and overflow/illegal-opcode exceptions.
module mc_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter bit EN_IMM      = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] iOp,
    input  logic       iMemReady,
    input  logic       iOverflow,
    output logic       oPCWr,
    output logic       oIRWr,
    output logic       oIorD,
    output logic       oMemRd,
    output logic       oMemWr,
    output logic       oMemtoReg,
    output logic       oRegDst,
    output logic       oRegWr,
    output logic       oALUSrcA,
    output logic       oBranch,
    output logic [1:0] oALUSrcB,
    output logic [1:0] oALUOp,
    output logic [1:0] oPCSrc,
    output logic       oCauseWr,
    output logic [1:0] oCause,
    output logic       oInstDone
);
    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTEXE, S_RTWB, S_BEQ, S_JMP, S_IMMEXE, S_IMMWB, S_EXC
    } state_t;
    state_t     state_q, state_d;
    logic [1:0] cause_q, cause_d, exc_cause;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout;
    assign timeout = !iMemReady && (cnt_q == 8'(MEM_TIMEOUT - 1));
    // Only the memory wait states ever loop on themselves, so a self-loop means "still waiting".
    assign cnt_d   = (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
    assign cause_d = (state_d == S_EXC) ? exc_cause : cause_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_RST;
            cause_q <= 2'b00;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        exc_cause = 2'b00;
        oPCWr     = 1'b0;
        oIRWr     = 1'b0;
        oIorD     = 1'b0;
        oMemRd    = 1'b0;
        oMemWr    = 1'b0;
        oMemtoReg = 1'b0;
        oRegDst   = 1'b0;
        oRegWr    = 1'b0;
        oALUSrcA  = 1'b0;
        oBranch   = 1'b0;
        oALUSrcB  = 2'b00;
        oALUOp    = 2'b00;
        oPCSrc    = 2'b00;
        oCauseWr  = 1'b0;
        oCause    = 2'b00;
        oInstDone = 1'b0;
        unique case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                oMemRd    = 1'b1;
                oALUSrcB  = 2'b01;
                oIRWr     = iMemReady;
                oPCWr     = iMemReady;
                exc_cause = 2'b10;
                state_d   = iMemReady ? S_DECODE : timeout ? S_EXC : S_FETCH;
            end
            S_DECODE: begin
                oALUSrcB  = 2'b11;
                exc_cause = 2'b11;
                state_d   = (iOp == 6'h23 || iOp == 6'h2B) ? S_MEMADR :
                            (iOp == 6'h00)                ? S_RTEXE  :
                            (iOp == 6'h04)                ? S_BEQ    :
                            (iOp == 6'h02)                ? S_JMP    :
                            (EN_IMM && iOp == 6'h08)      ? S_IMMEXE : S_EXC;
            end
            S_MEMADR: begin
                oALUSrcA = 1'b1;
                oALUSrcB = 2'b10;
                state_d  = (iOp == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                oMemRd    = 1'b1;
                oIorD     = 1'b1;
                exc_cause = 2'b10;
                state_d   = iMemReady ? S_MEMWB : timeout ? S_EXC : S_MEMRD;
            end
            S_MEMWB: begin
                oRegWr    = 1'b1;
                oInstDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                oMemWr    = 1'b1;
                oIorD     = 1'b1;
                oInstDone = iMemReady;
                exc_cause = 2'b10;
                state_d   = iMemReady ? S_FETCH : timeout ? S_EXC : S_MEMWR;
            end
            S_RTEXE: begin
                oALUSrcA = 1'b1;
                oALUOp   = 2'b10;
                state_d  = S_RTWB;
            end
            S_RTWB: begin
                oRegDst   = 1'b1;
                oMemtoReg = 1'b1;
                oRegWr    = ~iOverflow;
                oInstDone = 1'b1;
                exc_cause = 2'b01;
                state_d   = iOverflow ? S_EXC : S_FETCH;
            end
            S_IMMEXE: begin
                oALUSrcA = 1'b1;
                oALUSrcB = 2'b10;
                state_d  = S_IMMWB;
            end
            S_IMMWB: begin
                oMemtoReg = 1'b1;
                oRegWr    = ~iOverflow;
                oInstDone = 1'b1;
                exc_cause = 2'b01;
                state_d   = iOverflow ? S_EXC : S_FETCH;
            end
            S_BEQ: begin
                oALUSrcA  = 1'b1;
                oALUOp    = 2'b01;
                oBranch   = 1'b1;
                oPCSrc    = 2'b01;
                oInstDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_JMP: begin
                oPCWr     = 1'b1;
                oPCSrc    = 2'b10;
                oInstDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXC: begin
                oPCWr     = 1'b1;
                oPCSrc    = 2'b11;
                oCauseWr  = 1'b1;
                oCause    = cause_q;
                oInstDone = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed cycle-by-cycle checks of mc_control outputs against hand-computed vectors.
module tb_mc_control;
    // Output vector layout: {PCWr,IRWr,IorD,MemRd,MemWr}_{MemtoReg,RegDst,RegWr,SrcA,Branch}_SrcB_ALUOp_PCSrc_CauseWr_Cause_Done
    localparam logic [19:0] E_ZERO    = 20'b00000_00000_00_00_00_0_00_0;
    localparam logic [19:0] E_FETCH_R = 20'b11010_00000_01_00_00_0_00_0;
    localparam logic [19:0] E_FETCH_W = 20'b00010_00000_01_00_00_0_00_0;
    localparam logic [19:0] E_DECODE  = 20'b00000_00000_11_00_00_0_00_0;
    localparam logic [19:0] E_MEMADR  = 20'b00000_00010_10_00_00_0_00_0;
    localparam logic [19:0] E_MEMRD   = 20'b00110_00000_00_00_00_0_00_0;
    localparam logic [19:0] E_MEMWB   = 20'b00000_00100_00_00_00_0_00_1;
    localparam logic [19:0] E_MEMWR_W = 20'b00101_00000_00_00_00_0_00_0;
    localparam logic [19:0] E_MEMWR_R = 20'b00101_00000_00_00_00_0_00_1;
    localparam logic [19:0] E_RTEXE   = 20'b00000_00010_00_10_00_0_00_0;
    localparam logic [19:0] E_RTWB    = 20'b00000_11100_00_00_00_0_00_1;
    localparam logic [19:0] E_RTWB_V  = 20'b00000_11000_00_00_00_0_00_1;
    localparam logic [19:0] E_IMMEXE  = 20'b00000_00010_10_00_00_0_00_0;
    localparam logic [19:0] E_IMMWB   = 20'b00000_10100_00_00_00_0_00_1;
    localparam logic [19:0] E_BEQ     = 20'b00000_00011_00_01_01_0_00_1;
    localparam logic [19:0] E_JMP     = 20'b10000_00000_00_00_10_0_00_1;
    localparam logic [19:0] E_EXC_V   = 20'b10000_00000_00_00_11_1_01_1;
    localparam logic [19:0] E_EXC_T   = 20'b10000_00000_00_00_11_1_10_1;
    localparam logic [19:0] E_EXC_I   = 20'b10000_00000_00_00_11_1_11_1;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] iOp;
    logic       iMemReady, iOverflow;
    logic       pcwr, irwr, iord, memrd, memwr, memtoreg, regdst, regwr, srca, branch, causewr, done;
    logic [1:0] srcb, aluop, pcsrc, cause;
    logic       n_pcwr, n_irwr, n_iord, n_memrd, n_memwr, n_memtoreg, n_regdst, n_regwr, n_srca, n_branch, n_causewr, n_done;
    logic [1:0] n_srcb, n_aluop, n_pcsrc, n_cause;
    logic [19:0] outs, outs2;
    int vecs = 0;
    int errs = 0;

    assign outs  = {pcwr, irwr, iord, memrd, memwr, memtoreg, regdst, regwr, srca, branch,
                    srcb, aluop, pcsrc, causewr, cause, done};
    assign outs2 = {n_pcwr, n_irwr, n_iord, n_memrd, n_memwr, n_memtoreg, n_regdst, n_regwr, n_srca, n_branch,
                    n_srcb, n_aluop, n_pcsrc, n_causewr, n_cause, n_done};

    always #5 clk = ~clk;

    mc_control #(.MEM_TIMEOUT(4), .EN_IMM(1'b1)) dut (
        .clk(clk), .resetn(resetn), .iOp(iOp), .iMemReady(iMemReady), .iOverflow(iOverflow),
        .oPCWr(pcwr), .oIRWr(irwr), .oIorD(iord), .oMemRd(memrd), .oMemWr(memwr),
        .oMemtoReg(memtoreg), .oRegDst(regdst), .oRegWr(regwr), .oALUSrcA(srca), .oBranch(branch),
        .oALUSrcB(srcb), .oALUOp(aluop), .oPCSrc(pcsrc), .oCauseWr(causewr), .oCause(cause),
        .oInstDone(done)
    );

    mc_control #(.MEM_TIMEOUT(4), .EN_IMM(1'b0)) dut_noimm (
        .clk(clk), .resetn(resetn), .iOp(iOp), .iMemReady(iMemReady), .iOverflow(iOverflow),
        .oPCWr(n_pcwr), .oIRWr(n_irwr), .oIorD(n_iord), .oMemRd(n_memrd), .oMemWr(n_memwr),
        .oMemtoReg(n_memtoreg), .oRegDst(n_regdst), .oRegWr(n_regwr), .oALUSrcA(n_srca), .oBranch(n_branch),
        .oALUSrcB(n_srcb), .oALUOp(n_aluop), .oPCSrc(n_pcsrc), .oCauseWr(n_causewr), .oCause(n_cause),
        .oInstDone(n_done)
    );

    task automatic test_reset();
        resetn = 1'b0; iMemReady = 1'b1; iOp = 6'h00; iOverflow = 1'b0;
        @(posedge clk); #1;
        vecs++;
        if (outs !== E_ZERO || outs2 !== E_ZERO) begin
            errs++; $display("FAIL reset_held outs=%b outs2=%b expected=%b", outs, outs2, E_ZERO);
        end
        resetn = 1'b1; #1;
        vecs++;
        if (outs !== E_ZERO) begin errs++; $display("FAIL reset_release outs=%b expected=%b", outs, E_ZERO); end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        logic [19:0] e[8] = '{E_FETCH_R, E_DECODE, E_RTEXE, E_RTWB, E_FETCH_R, E_DECODE, E_RTEXE, E_RTWB};
        iOp = 6'h00; iOverflow = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iMemReady = 1'b1; #1;
            vecs++;
            if (outs !== e[i]) begin errs++; $display("FAIL rtype cyc%0d outs=%b expected=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        logic        r[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [19:0] e[8] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
        iOp = 6'h23; iOverflow = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iMemReady = r[i]; #1;
            vecs++;
            if (outs !== e[i]) begin errs++; $display("FAIL lw_wait cyc%0d outs=%b expected=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_timeout();
        logic [19:0] e[8] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR_W, E_MEMWR_W, E_MEMWR_W, E_MEMWR_W, E_EXC_T};
        iOp = 6'h2B; iOverflow = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iMemReady = (i == 0); #1;
            vecs++;
            if (outs !== e[i]) begin errs++; $display("FAIL sw_timeout cyc%0d outs=%b expected=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_ready_at_limit();
        logic        r[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [19:0] e[7] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR_W, E_MEMWR_W, E_MEMWR_W, E_MEMWR_R};
        iOp = 6'h2B; iOverflow = 1'b0;
        for (int i = 0; i < 7; i++) begin
            iMemReady = r[i]; #1;
            vecs++;
            if (outs !== e[i]) begin errs++; $display("FAIL sw_ready4 cyc%0d outs=%b expected=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_timeout();
        logic [19:0] e[5] = '{E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_W, E_EXC_T};
        iOp = 6'h00; iOverflow = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iMemReady = 1'b0; #1;
            vecs++;
            if (outs !== e[i]) begin errs++; $display("FAIL fetch_timeout cyc%0d outs=%b expected=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overflow();
        logic        v[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [19:0] e[5] = '{E_FETCH_R, E_DECODE, E_RTEXE, E_RTWB_V, E_EXC_V};
        iOp = 6'h00;
        for (int i = 0; i < 5; i++) begin
            iMemReady = 1'b1; iOverflow = v[i]; #1;
            vecs++;
            if (outs !== e[i]) begin errs++; $display("FAIL overflow cyc%0d outs=%b expected=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
        iOverflow = 1'b0;
    endtask

    task automatic test_branch_jump();
        logic [19:0] e[6] = '{E_FETCH_R, E_DECODE, E_BEQ, E_FETCH_R, E_DECODE, E_JMP};
        iOverflow = 1'b0;
        for (int i = 0; i < 6; i++) begin
            iMemReady = 1'b1; iOp = (i < 3) ? 6'h04 : 6'h02; #1;
            vecs++;
            if (outs !== e[i]) begin errs++; $display("FAIL beq_j cyc%0d outs=%b expected=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [19:0] e[3] = '{E_FETCH_R, E_DECODE, E_EXC_I};
        iOp = 6'h3F; iOverflow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iMemReady = 1'b1; #1;
            vecs++;
            if (outs !== e[i]) begin errs++; $display("FAIL illegal cyc%0d outs=%b expected=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_beq();
        logic [19:0] e[3] = '{E_FETCH_R, E_DECODE, E_BEQ};
        iOp = 6'h04; iOverflow = 1'b0; iMemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++;
            if (outs !== e[i]) begin errs++; $display("FAIL beq_pre_reset cyc%0d outs=%b expected=%b", i, outs, e[i]); end
            if (i < 2) begin @(posedge clk); #1; end
        end
        resetn = 1'b0; #1;
        vecs++;
        if (outs !== E_ZERO) begin errs++; $display("FAIL async_reset outs=%b expected=%b", outs, E_ZERO); end
        @(posedge clk); #1;
        resetn = 1'b1; #1;
        vecs++;
        if (outs !== E_ZERO) begin errs++; $display("FAIL async_reset_release outs=%b expected=%b", outs, E_ZERO); end
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        logic [19:0] e[4]  = '{E_FETCH_R, E_DECODE, E_IMMEXE, E_IMMWB};
        logic [19:0] e2[4] = '{E_FETCH_R, E_DECODE, E_EXC_I, E_FETCH_R};
        iOp = 6'h08; iOverflow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iMemReady = 1'b1; #1;
            vecs++;
            if (outs !== e[i] || outs2 !== e2[i]) begin
                errs++;
                $display("FAIL addi cyc%0d outs=%b expected=%b noimm_outs=%b expected=%b", i, outs, e[i], outs2, e2[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_timeout();
        test_sw_ready_at_limit();
        test_fetch_timeout();
        test_overflow();
        test_branch_jump();
        test_illegal();
        test_reset_in_beq();
        test_addi();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
